// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory bus arbiter.
// Used by the arbiter and by the decode logic (LDR/STR opcodes).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [3:0] OP_LDR = 4'b1101;
  localparam logic [3:0] OP_STR = 4'b1110;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_timer.sv
// Loadable down-counter with zero flag.
// Counts the remaining cycles of one bus access.
module mem_lat_timer #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam logic [3:0] LOAD_VAL = 4'(MEM_LAT - 1);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Fetch/data arbiter for the single external memory bus.
// Optional perf counters: define MEM_ARB_PERF_CNT_EN.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT        = 1,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [7:0]  if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [15:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_rw,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
`ifdef MEM_ARB_PERF_CNT_EN
  output logic [15:0] perf_if_cnt,
  output logic [15:0] perf_dm_cnt,
  output logic [15:0] perf_stall_cnt,
`endif
  output logic        busy
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_rw_q, mem_rw_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  burst_q, burst_d;
  logic        if_ack_q, if_ack_d;
  logic        dm_ack_q, dm_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;

  logic        tmr_load;
  logic        tmr_dec;
  logic        lat_zero;
  logic        if_grant;
  logic        dm_grant;
  logic        burst_full;

  mem_lat_timer #(
    .MEM_LAT (MEM_LAT)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .dec   (tmr_dec),
    .zero  (lat_zero)
  );

  // Data has priority until it has starved a waiting fetch long enough.
  assign burst_full = (burst_q == BURST_MAX);
  assign dm_grant   = (state_q == IDLE) && dm_req && !(if_req && burst_full);
  assign if_grant   = (state_q == IDLE) && if_req && !dm_grant;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    mem_en_d   = mem_en_q;
    mem_rw_d   = mem_rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    burst_d    = burst_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!if_req) begin
          burst_d = 4'd0;
        end
        if (dm_grant) begin
          owner_d  = OWN_DM;
          addr_d   = dm_addr;
          mem_rw_d = dm_we ? RW_WRITE : RW_READ;
          wdata_d  = dm_wdata;
          if (if_req && !burst_full) begin
            burst_d = burst_q + 4'd1;
          end
        end else if (if_grant) begin
          owner_d  = OWN_IF;
          addr_d   = {8'h00, if_addr};
          mem_rw_d = RW_READ;
          burst_d  = 4'd0;
        end
        if (dm_grant || if_grant) begin
          mem_en_d = 1'b1;
          tmr_load = 1'b1;
          state_d  = ACCESS;
        end
      end

      ACCESS: begin
        tmr_dec = 1'b1;
        if (lat_zero) begin
          state_d  = DONE;
          mem_en_d = 1'b0;
          mem_rw_d = RW_READ;
          if (owner_q == OWN_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            dm_ack_d = 1'b1;
            if (mem_rw_q == RW_READ) begin
              dm_rdata_d = mem_rdata;
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d  = IDLE;
        mem_en_d = 1'b0;
        mem_rw_d = RW_READ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      mem_en_q   <= 1'b0;
      mem_rw_q   <= RW_READ;
      addr_q     <= 16'h0000;
      wdata_q    <= 32'h0;
      burst_q    <= 4'd0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      if_rdata_q <= 32'h0;
      dm_rdata_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      mem_en_q   <= mem_en_d;
      mem_rw_q   <= mem_rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      burst_q    <= burst_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign busy      = (state_q != IDLE);

`ifdef MEM_ARB_PERF_CNT_EN
  logic [15:0] perf_if_q, perf_if_d;
  logic [15:0] perf_dm_q, perf_dm_d;
  logic [15:0] perf_st_q, perf_st_d;
  logic        if_stall;

  // A fetch stalls whenever it is asserted but not being granted right now.
  assign if_stall = if_req && !if_grant;

  always_comb begin
    perf_if_d = perf_if_q;
    perf_dm_d = perf_dm_q;
    perf_st_d = perf_st_q;
    if (state_q == DONE) begin
      if (owner_q == OWN_IF) begin
        perf_if_d = sat_inc16(perf_if_q);
      end else begin
        perf_dm_d = sat_inc16(perf_dm_q);
      end
    end
    if (if_stall) begin
      perf_st_d = sat_inc16(perf_st_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_q <= 16'h0;
      perf_dm_q <= 16'h0;
      perf_st_q <= 16'h0;
    end else begin
      perf_if_q <= perf_if_d;
      perf_dm_q <= perf_dm_d;
      perf_st_q <= perf_st_d;
    end
  end

  assign perf_if_cnt    = perf_if_q;
  assign perf_dm_cnt    = perf_dm_q;
  assign perf_stall_cnt = perf_st_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter (MEM_LAT=3, MAX_DATA_BURST=4).
// Expected bus transfers are queued at drive time and retired on ack.
module tb_mem_bus_arbiter;

  localparam int LAT   = 3;
  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [7:0]  if_addr = 8'h00;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [15:0] dm_addr = 16'h0;
  logic [31:0] dm_wdata = 32'h0;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        mem_en;
  logic        mem_rw;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .MEM_LAT        (LAT),
    .MAX_DATA_BURST (BURST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ack    (dm_ack),
    .dm_rdata  (dm_rdata),
    .mem_en    (mem_en),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  typedef struct {
    logic        is_dm;
    logic        rd;
    logic [15:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   ack_seen = 0;

  function automatic logic [31:0] mem_model(input logic [15:0] a);
    if (a == 16'h002A) return 32'hDEADBEEF;
    return {a ^ 16'h5A5A, a};
  endfunction

  assign mem_rdata = (mem_en && mem_rw) ? mem_model(mem_addr)
                                        : 32'h0BAD0BAD;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic is_dm, input logic rd,
                      input logic [15:0] a, input logic [31:0] wd);
    exp_t e;
    e.is_dm = is_dm;
    e.rd    = rd;
    e.addr  = a;
    e.wdata = wd;
    q.push_back(e);
  endtask

  int          run = 0;
  logic [31:0] last_dm = 32'h0;
  logic        prev_if_ack = 1'b0;
  logic        prev_dm_ack = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
      last_dm = 32'h0;
      prev_if_ack = 1'b0;
      prev_dm_ack = 1'b0;
    end else begin
      if (prev_if_ack) chk("if_ack_pulse", if_ack, 0);
      if (prev_dm_ack) chk("dm_ack_pulse", dm_ack, 0);
      if (mem_en) begin
        run++;
        chk("busy_access", busy, 1);
        if (q.size() > 0) begin
          chk("mem_addr", mem_addr, q[0].addr);
          chk("mem_rw", mem_rw, q[0].rd);
          if (!q[0].rd) chk("mem_wdata", mem_wdata, q[0].wdata);
        end
      end else begin
        if (if_ack || dm_ack) begin
          ack_seen++;
          chk("ack_excl", if_ack & dm_ack, 0);
          chk("ack_lat", run, LAT);
          chk("done_mem_rw", mem_rw, 1);
          if (q.size() == 0) begin
            chk("spurious_ack", 1, 0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("ack_owner", dm_ack, e.is_dm);
            if (!e.is_dm) begin
              chk("if_rdata", if_rdata, mem_model(e.addr));
            end else if (e.rd) begin
              chk("dm_rdata", dm_rdata, mem_model(e.addr));
              last_dm = mem_model(e.addr);
            end else begin
              chk("dm_rdata_hold", dm_rdata, last_dm);
            end
          end
        end
        run = 0;
      end
      prev_if_ack = if_ack;
      prev_dm_ack = dm_ack;
    end
  end

  task automatic if_xfer(input logic [7:0] a, input int lat);
    int n = 0;
    bit got = 0;
    if_req  = 1'b1;
    if_addr = a;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (if_ack) begin
        got = 1;
        break;
      end
      n++;
    end
    if (!got) chk("if_timeout", 0, 1);
    else if (lat >= 0) chk("if_lat", n, lat);
    @(posedge clk);
    #1;
    if_req = 1'b0;
  endtask

  task automatic dm_xfer(input logic we, input logic [15:0] a,
                         input logic [31:0] wd, input int lat,
                         input logic keep);
    int n = 0;
    bit got = 0;
    dm_req   = 1'b1;
    dm_we    = we;
    dm_addr  = a;
    dm_wdata = wd;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dm_ack) begin
        got = 1;
        break;
      end
      n++;
    end
    if (!got) chk("dm_timeout", 0, 1);
    else if (lat >= 0) chk("dm_lat", n, lat);
    @(posedge clk);
    #1;
    if (!keep) dm_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_mem_en"}, mem_en, 0);
    chk({pfx, "_mem_rw"}, mem_rw, 1);
    chk({pfx, "_mem_addr"}, mem_addr, 0);
    chk({pfx, "_mem_wdata"}, mem_wdata, 0);
    chk({pfx, "_if_ack"}, if_ack, 0);
    chk({pfx, "_dm_ack"}, dm_ack, 0);
    chk({pfx, "_if_rdata"}, if_rdata, 0);
    chk({pfx, "_dm_rdata"}, dm_rdata, 0);
    chk({pfx, "_busy"}, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    bit got;

    #12;
    chk_reset_outs("rst");
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // reset in the second ACCESS cycle of a fetch
    if_req  = 1'b1;
    if_addr = 8'h55;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    chk("mid_mem_en", mem_en, 1);
    rst_n  = 1'b0;
    if_req = 1'b0;
    #1;
    chk_reset_outs("midrst");
    a0 = ack_seen;
    #2;
    rst_n = 1'b1;
    idle(10);
    chk("no_ack_after_rst", ack_seen - a0, 0);

    // single fetch
    push(1'b0, 1'b1, 16'h002A, 32'h0);
    if_xfer(8'h2A, LAT + 1);
    idle(2);

    // load then store, store must not disturb dm_rdata
    push(1'b1, 1'b1, 16'h0300, 32'h0);
    dm_xfer(1'b0, 16'h0300, 32'h0, LAT + 1, 1'b0);
    idle(2);
    push(1'b1, 1'b0, 16'h1234, 32'hCAFEF00D);
    dm_xfer(1'b1, 16'h1234, 32'hCAFEF00D, LAT + 1, 1'b0);
    idle(2);

    // simultaneous requests: data first, fetch MEM_LAT+2 later
    push(1'b1, 1'b1, 16'h0400, 32'h0);
    push(1'b0, 1'b1, 16'h0011, 32'h0);
    fork
      if_xfer(8'h11, 2 * LAT + 3);
      dm_xfer(1'b0, 16'h0400, 32'h0, LAT + 1, 1'b0);
    join
    idle(2);

    // starvation guard: D,D,D,D,F,D
    for (int i = 0; i < 4; i++) push(1'b1, 1'b1, 16'(16'h0100 + i), 32'h0);
    push(1'b0, 1'b1, 16'h0077, 32'h0);
    push(1'b1, 1'b1, 16'h0104, 32'h0);
    fork
      begin
        for (int i = 0; i < 5; i++)
          dm_xfer(1'b0, 16'(16'h0100 + i), 32'h0, -1, i < 4);
      end
      if_xfer(8'h77, -1);
    join
    idle(2);

    // request dropped during ACCESS still completes
    push(1'b1, 1'b1, 16'h0500, 32'h0);
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 16'h0500;
    @(posedge clk);
    #1;
    dm_req  = 1'b0;
    dm_addr = 16'hFFFF;
    dm_we   = 1'b1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dm_ack) begin
        got = 1;
        break;
      end
    end
    chk("drop_ack_seen", got, 1);
    idle(3);

    chk("queue_empty", q.size(), 0);
    chk("final_busy", busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Sequences and shares the single external memory bus between two requesters: instruction fetch (PC-addressed) and data access (LDR/STR).
- Sits between the fetch stage / mem_control_unit and the memory device.
- Owns the address mux select and rw policy, and handles fixed-latency memory timing.
- Data has priority; a burst limit prevents fetch starvation.

Parameters:
- MEM_LAT, 1, memory access cycles per transfer, legal range 1..15.
- MAX_DATA_BURST, 4, consecutive data grants allowed while fetch waits, legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  8  fetch address (PC), zero-extended to 16 bits.
- if_ack  out  1  one-cycle completion pulse for fetch.
- if_rdata  out  32  fetched word; valid while if_ack=1 and held until the next fetch completes.
- dm_req  in  1  data request; held until dm_ack.
- dm_we  in  1  1=store (STR), 0=load (LDR).
- dm_addr  in  16  data address.
- dm_wdata  in  32  store data.
- dm_ack  out  1  one-cycle completion pulse for data.
- dm_rdata  out  32  load data; valid while dm_ack=1 and held until the next load completes.
- mem_en  out  1  bus access active.
- mem_rw  out  1  1=read, 0=write.
- mem_addr  out  16  bus address.
- mem_wdata  out  32  bus write data.
- mem_rdata  in  32  bus read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any state, including mid-access):
  - State goes to IDLE.
  - mem_en=0, mem_rw=1, mem_addr=0, mem_wdata=0.
  - if_ack=dm_ack=0, if_rdata=dm_rdata=0, busy=0, burst counter=0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, grant decision when a request is present:
  - Data wins if dm_req=1, unless if_req=1 and burst_cnt==MAX_DATA_BURST; in that case fetch wins.
  - Otherwise fetch wins if if_req=1.
  - No request: remain in IDLE.
- On grant, latch owner, address (fetch: {8'h00, if_addr}), rw (fetch always read; data: ~dm_we) and wdata. Load lat_cnt=MEM_LAT-1. Go to ACCESS.
- ACCESS:
  - mem_en=1; mem_addr/mem_rw/mem_wdata come from the latched registers and are stable for all MEM_LAT cycles.
  - Requester inputs may change without effect.
  - Decrement lat_cnt each cycle. At lat_cnt==0, capture mem_rdata (reads only) and go to DONE.
- DONE:
  - mem_en=0, mem_rw=1.
  - The owner's ack=1 for exactly this cycle; its rdata register now holds the captured word. Store acks leave dm_rdata unchanged.
  - Next state is IDLE.
- Latency: request sampled in IDLE at cycle T; ack at cycle T+MEM_LAT+1. Minimum back-to-back spacing between acks is MEM_LAT+2 cycles.
- Requester rule: req must be deasserted, or re-asserted for a new transfer, by the cycle after ack. A req seen in IDLE after DONE is always a new transfer.
- Burst counter (saturating at MAX_DATA_BURST):
  - Increments on each data grant while if_req=1.
  - Clears on a fetch grant, or in any IDLE cycle with if_req=0.
- Simultaneous if_req/dm_req with burst_cnt<MAX: data granted.
- Request dropped during ACCESS: the transfer still completes and acks.
- mem_rdata is don't-care except in the capture cycle.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_if_cnt[15:0], perf_dm_cnt[15:0] and perf_stall_cnt[15:0], all saturating at 16'hFFFF and cleared by reset.
  - perf_if_cnt / perf_dm_cnt count completed transfers (DONE cycles per owner).
  - perf_stall_cnt counts cycles with if_req=1 while the owner is not fetch, or the arbiter is not in IDLE.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - State enum (IDLE/ACCESS/DONE).
  - Owner encoding (OWN_IF=0, OWN_DM=1).
  - RW_READ=1'b1 and RW_WRITE=1'b0.
  - Opcode constants OP_LDR=4'b1101 and OP_STR=4'b1110, shared with the decode logic.
- One sub-module, mem_lat_timer: loadable down-counter with a zero flag, parameterised by MEM_LAT.

Test Plan:
- Reset mid-access: MEM_LAT=3, grant a fetch, assert rst_n=0 in the 2nd ACCESS cycle -> all outputs at reset values immediately; no ack after release.
- Single fetch: if_addr=8'h2A, mem returns 32'hDEADBEEF -> mem_addr=16'h002A with mem_rw=1 for MEM_LAT cycles; if_ack pulses at T+MEM_LAT+1 with if_rdata=DEADBEEF.
- Store: dm_we=1, dm_addr=16'h1234, dm_wdata=32'hCAFEF00D -> mem_rw=0 with addr/data stable during ACCESS; dm_ack one cycle; dm_rdata unchanged.
- Simultaneous requests: if_req and dm_req both high at cycle 0 -> data served first, then fetch; if_ack follows dm_ack by MEM_LAT+2 cycles.
- Starvation guard: MAX_DATA_BURST=4, dm_req held continuously with if_req=1 -> grant order D,D,D,D,F,D...
- Perf counters (macro defined): 3 fetches + 2 loads -> perf_if_cnt=3, perf_dm_cnt=2; perf_stall_cnt equals the number of waiting-fetch cycles.
